// File: rtl/ccis_fiu_mem_responder.sv
// CCI-style FIU memory responder: line-addressed backing store with fixed-latency,
// in-order read/write responses, per-channel back-pressure, almost-full and overflow flags.

module ccis_fiu_rsp_chan #(
    parameter int unsigned LAT       = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ALM_SLACK = 4,
    parameter int unsigned PW        = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          req_valid,
    input  logic [PW-1:0] req_payload,
    input  logic          stall,
    output logic          rsp_valid,
    output logic [PW-1:0] rsp_payload,
    output logic          alm_full,
    output logic          accept,
    output logic          req_err
);
    localparam int unsigned OCCW = $clog2(DEPTH + 1);
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NSTG = LAT - 1;
    localparam logic [OCCW-1:0] OCC_FULL = OCCW'(DEPTH);
    localparam logic [OCCW-1:0] OCC_ALM  = OCCW'(DEPTH - ALM_SLACK);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);

    logic [NSTG-1:0] pv_q, pv_d;
    logic [PW-1:0]   pp_q [NSTG];
    logic [PW-1:0]   pp_d [NSTG];
    logic [PW-1:0]   fifo_q [DEPTH];
    logic [PTRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OCCW-1:0] fcnt_q, fcnt_d, occ_q, occ_d;
    logic            push, pop, full;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Requests age through a LAT-1 stage delay line, then land in the FIFO so the
    // head is visible exactly LAT cycles after acceptance when unstalled.
    always_comb begin
        full        = (occ_q == OCC_FULL);
        accept      = req_valid & run & ~full;
        req_err     = req_valid & ~accept;
        push        = pv_q[NSTG-1];
        pop         = (fcnt_q != '0) & ~stall & ~reset;
        rsp_valid   = pop;
        rsp_payload = fifo_q[rptr_q];
        alm_full    = ~reset & (occ_q >= OCC_ALM);

        pv_d    = pv_q;
        pp_d    = pp_q;
        pv_d[0] = accept;
        pp_d[0] = req_payload;
        for (int unsigned k = 1; k < NSTG; k++) begin
            pv_d[k] = pv_q[k-1];
            pp_d[k] = pp_q[k-1];
        end

        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;

        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase

        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            occ_q  <= '0;
        end else begin
            pv_q   <= pv_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fcnt_q <= fcnt_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        pp_q <= pp_d;
        if (push) begin
            fifo_q[wptr_q] <= pp_q[NSTG-1];
        end
    end
endmodule

module ccis_fiu_mem_responder #(
    parameter int unsigned MEM_LINES  = 64,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned WR_LATENCY = 3,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ALM_SLACK  = 4
) (
    input  logic         vl_clk_LPdomain_32ui,
    input  logic         reset,
    input  logic         c0_tx_rd_valid,
    input  logic [31:0]  c0_tx_addr,
    input  logic [12:0]  c0_tx_mdata,
    input  logic         c1_tx_wr_valid,
    input  logic [31:0]  c1_tx_addr,
    input  logic [12:0]  c1_tx_mdata,
    input  logic [511:0] c1_tx_data,
    input  logic         c0_rsp_stall,
    input  logic         c1_rsp_stall,
    output logic         c0_rx_rd_valid,
    output logic [12:0]  c0_rx_mdata,
    output logic [511:0] c0_rx_data,
    output logic         c1_rx_wr_valid,
    output logic [12:0]  c1_rx_mdata,
    output logic         c0_tx_alm_full,
    output logic         c1_tx_alm_full,
    output logic         init_done,
    output logic         overflow_err
);
    localparam int unsigned IDXW = $clog2(MEM_LINES);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic         clk;
    logic [0:0]   state_q, state_d;
    logic [3:0]   init_cnt_q, init_cnt_d;
    logic         err_q, err_d;
    logic         run;
    logic [IDXW-1:0] rd_idx, wr_idx;
    logic [511:0] mem_q [MEM_LINES];
    logic [524:0] rd_req_payload, rd_rsp_payload;
    logic         rd_accept, rd_err, wr_accept, wr_err;
    logic         unused_addr_bits;

    assign clk = vl_clk_LPdomain_32ui;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            if (init_cnt_q == 4'd15) begin
                state_d    = ST_RUN;
                init_cnt_d = '0;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end

        run            = (state_q == ST_RUN) & ~reset;
        rd_idx         = c0_tx_addr[IDXW-1:0];
        wr_idx         = c1_tx_addr[IDXW-1:0];
        rd_req_payload = {c0_tx_mdata, mem_q[rd_idx]};
        err_d          = err_q | rd_err | wr_err;

        init_done    = run;
        overflow_err = err_q & ~reset;
        c0_rx_mdata  = rd_rsp_payload[524:512];
        c0_rx_data   = rd_rsp_payload[511:0];
    end

    assign unused_addr_bits = ^{c0_tx_addr[31:IDXW], c1_tx_addr[31:IDXW], rd_accept};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            err_q      <= err_d;
        end
    end

    // Read data is captured from the array in the acceptance cycle, before this edge's write lands.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_idx] <= c1_tx_data;
        end
    end

    ccis_fiu_rsp_chan #(
        .LAT       (RD_LATENCY),
        .DEPTH     (DEPTH),
        .ALM_SLACK (ALM_SLACK),
        .PW        (525)
    ) u_rd_chan (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .req_valid   (c0_tx_rd_valid),
        .req_payload (rd_req_payload),
        .stall       (c0_rsp_stall),
        .rsp_valid   (c0_rx_rd_valid),
        .rsp_payload (rd_rsp_payload),
        .alm_full    (c0_tx_alm_full),
        .accept      (rd_accept),
        .req_err     (rd_err)
    );

    ccis_fiu_rsp_chan #(
        .LAT       (WR_LATENCY),
        .DEPTH     (DEPTH),
        .ALM_SLACK (ALM_SLACK),
        .PW        (13)
    ) u_wr_chan (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .req_valid   (c1_tx_wr_valid),
        .req_payload (c1_tx_mdata),
        .stall       (c1_rsp_stall),
        .rsp_valid   (c1_rx_wr_valid),
        .rsp_payload (c1_rx_mdata),
        .alm_full    (c1_tx_alm_full),
        .accept      (wr_accept),
        .req_err     (wr_err)
    );
endmodule
